// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences fetch/decode/exec/mem/wb for one instruction at a time.
// Latency 3-5 cycles plus memory waits; stalls on imem_valid/dmem_ready, traps after TIMEOUT idle cycles.
module multicycle_control #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instr,
   input  logic             imem_valid,
   input  logic             dmem_ready,
   input  logic             alu_zero,
   output logic             imem_req,
   output logic             ir_we,
   output logic             imm_sel,
   output logic             alu_src_imm,
   output logic [1:0]       alu_op,
   output logic             dmem_re,
   output logic             dmem_we,
   output logic             wb_sel,
   output logic             reg_we,
   output logic             pc_we,
   output logic             pc_src,
   output logic             fault,
   output logic [CNT_W-1:0] retired
);

   localparam int                WAIT_W    = $clog2(TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_TRAP   = 3'd5;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   typedef struct packed {
      logic       imem_req;
      logic       ir_we;
      logic       imm_sel;
      logic       alu_src_imm;
      logic [1:0] alu_op;
      logic       dmem_re;
      logic       dmem_we;
      logic       wb_sel;
      logic       reg_we;
      logic       pc_we;
      logic       pc_src;
   } ctrl_t;

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [6:0]        opc_q;
   logic              bne_q;
   ctrl_t             ctrl;
   logic              dec_legal;
   logic              wait_last;
   logic              mem_timeout;
   logic              is_load_q;
   logic              is_store_q;
   logic              unused_instr_bits;

   assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

   assign wait_last   = (wait_cnt == WAIT_LAST);
   assign mem_timeout = wait_last && !dmem_ready;
   assign is_load_q   = (opc_q == OPC_LOAD);
   assign is_store_q  = (opc_q == OPC_STORE);

   // Only BEQ/BNE are legal branches: funct3 must be 00x.
   always_comb begin
      dec_legal = 1'b0;
      case (instr[6:0])
         OPC_OP_IMM, OPC_OP, OPC_LOAD, OPC_STORE: dec_legal = 1'b1;
         OPC_BRANCH:                              dec_legal = (instr[14:13] == 2'b00);
         default:                                 dec_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH: begin
            if (imem_valid)     state_nxt = S_DECODE;
            else if (wait_last) state_nxt = S_TRAP;
         end
         S_DECODE: state_nxt = dec_legal ? S_EXEC : S_TRAP;
         S_EXEC: begin
            case (opc_q)
               OPC_OP, OPC_OP_IMM:  state_nxt = S_WB;
               OPC_LOAD, OPC_STORE: state_nxt = S_MEM;
               default:             state_nxt = S_FETCH;
            endcase
         end
         S_MEM: begin
            if (dmem_ready)     state_nxt = is_load_q ? S_WB : S_FETCH;
            else if (wait_last) state_nxt = S_TRAP;
         end
         S_WB:    state_nxt = S_FETCH;
         S_TRAP:  state_nxt = S_TRAP;
         default: state_nxt = S_TRAP;
      endcase
   end

   // Strobes are suppressed while rst is high so nothing commits on the reset edge.
   always_comb begin
      ctrl = '0;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               ctrl.imem_req = 1'b1;
               ctrl.ir_we    = imem_valid;
            end
            S_DECODE: ctrl.imm_sel = (instr[6:0] == OPC_STORE);
            S_EXEC: begin
               ctrl.imm_sel = is_store_q;
               case (opc_q)
                  OPC_OP: begin
                     ctrl.alu_src_imm = 1'b0;
                     ctrl.alu_op      = ALU_FUNCT;
                  end
                  OPC_OP_IMM: begin
                     ctrl.alu_src_imm = 1'b1;
                     ctrl.alu_op      = ALU_FUNCT;
                  end
                  OPC_LOAD, OPC_STORE: begin
                     ctrl.alu_src_imm = 1'b1;
                     ctrl.alu_op      = ALU_ADD;
                  end
                  default: begin
                     ctrl.alu_src_imm = 1'b0;
                     ctrl.alu_op      = ALU_SUB;
                     ctrl.pc_we       = 1'b1;
                     ctrl.pc_src      = bne_q ? !alu_zero : alu_zero;
                  end
               endcase
            end
            S_MEM: begin
               ctrl.imm_sel     = is_store_q;
               ctrl.alu_src_imm = 1'b1;
               ctrl.alu_op      = ALU_ADD;
               if (!mem_timeout) begin
                  ctrl.dmem_re = is_load_q;
                  ctrl.dmem_we = is_store_q;
                  ctrl.pc_we   = is_store_q && dmem_ready;
               end
            end
            S_WB: begin
               ctrl.imm_sel = is_store_q;
               ctrl.wb_sel  = is_load_q;
               ctrl.reg_we  = 1'b1;
               ctrl.pc_we   = 1'b1;
            end
            default: ctrl = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
         opc_q    <= '0;
         bne_q    <= 1'b0;
         retired  <= '0;
      end else begin
         state <= state_nxt;
         if ((state == S_FETCH && !imem_valid) || (state == S_MEM && !dmem_ready))
            wait_cnt <= wait_cnt + 1'b1;
         else
            wait_cnt <= '0;
         if (state == S_DECODE) begin
            opc_q <= instr[6:0];
            bne_q <= instr[12];
         end
         if (ctrl.pc_we)
            retired <= retired + 1'b1;
      end
   end

   assign imem_req    = ctrl.imem_req;
   assign ir_we       = ctrl.ir_we;
   assign imm_sel     = ctrl.imm_sel;
   assign alu_src_imm = ctrl.alu_src_imm;
   assign alu_op      = ctrl.alu_op;
   assign dmem_re     = ctrl.dmem_re;
   assign dmem_we     = ctrl.dmem_we;
   assign wb_sel      = ctrl.wb_sel;
   assign reg_we      = ctrl.reg_we;
   assign pc_we       = ctrl.pc_we;
   assign pc_src      = ctrl.pc_src;
   assign fault       = (state == S_TRAP);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios plus random instruction streams
// checked against per-instruction latency and strobe-count expectations.
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        imem_valid;
   logic        dmem_ready;
   logic        alu_zero;
   logic        imem_req;
   logic        ir_we;
   logic        imm_sel;
   logic        alu_src_imm;
   logic [1:0]  alu_op;
   logic        dmem_re;
   logic        dmem_we;
   logic        wb_sel;
   logic        reg_we;
   logic        pc_we;
   logic        pc_src;
   logic        fault;
   logic [31:0] retired;

   always #5 clk = ~clk;

   multicycle_control #(.TIMEOUT(16), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .instr(instr), .imem_valid(imem_valid),
      .dmem_ready(dmem_ready), .alu_zero(alu_zero), .imem_req(imem_req),
      .ir_we(ir_we), .imm_sel(imm_sel), .alu_src_imm(alu_src_imm),
      .alu_op(alu_op), .dmem_re(dmem_re), .dmem_we(dmem_we), .wb_sel(wb_sel),
      .reg_we(reg_we), .pc_we(pc_we), .pc_src(pc_src), .fault(fault),
      .retired(retired)
   );

   // Observation vector bit positions
   localparam int B_FAULT = 0, B_PCSRC = 1, B_PCWE = 2, B_REGWE = 3, B_WBSEL = 4;
   localparam int B_DWE = 5, B_DRE = 6, B_ASRC = 9, B_IMM = 10, B_IRWE = 11, B_IREQ = 12;

   localparam logic [6:0] OP_IMM = 7'b0010011, OP_REG = 7'b0110011, OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011, OP_BR = 7'b1100011;

   logic [12:0] obs     [0:63];
   logic [31:0] ret_obs [0:63];
   int          n_checks = 0;
   int          n_errors = 0;
   int          exp_ret  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; imem_valid = 1'b0; dmem_ready = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_ret = 0;
   endtask

   // Memory model: imem answers in fetch cycle di, dmem in the dm-th cycle of the access.
   task automatic run(input logic [31:0] ins, input int di, input int dm, input bit z,
                      input int ncyc, input int rst_at);
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk);
         instr      = ins;
         imem_valid = (k == di);
         dmem_ready = (k == di + 3 + dm);
         alu_zero   = z;
         rst        = (k == rst_at);
         #1;
         obs[k] = {imem_req, ir_we, imm_sel, alu_src_imm, alu_op, dmem_re, dmem_we,
                   wb_sel, reg_we, pc_we, pc_src, fault};
         ret_obs[k] = retired;
      end
   endtask

   task automatic check_retired(input string tag);
      @(posedge clk);
      #1 check(tag, retired, exp_ret);
   endtask

   function automatic int count_bit(input int b, input int lo, input int hi);
      int c = 0;
      for (int k = lo; k <= hi; k++) if (obs[k][b]) c++;
      return c;
   endfunction

   function automatic bit supported(input logic [6:0] opc);
      return opc == OP_IMM || opc == OP_REG || opc == OP_LOAD || opc == OP_STORE || opc == OP_BR;
   endfunction

   initial begin
      int c;
      rst = 1'b1; instr = '0; imem_valid = 1'b0; dmem_ready = 1'b0; alu_zero = 1'b0;

      // Reset state
      do_reset();
      @(negedge clk); #1;
      check("reset_outputs", {imem_req, ir_we, imm_sel, alu_src_imm, alu_op, dmem_re, dmem_we,
                              wb_sel, reg_we, pc_we, pc_src, fault}, 32'h1000);
      check("reset_retired", retired, 0);

      // ADDI x1,x0,5
      do_reset();
      run(32'h00500093, 0, 0, 1'b0, 4, -1);
      check("addi_fetch",  obs[0], 32'h1800);
      check("addi_decode", obs[1], 32'h0000);
      check("addi_exec",   obs[2], 32'h0300);
      check("addi_wb",     obs[3], 32'h000C);
      exp_ret = 1;
      check_retired("addi_retired");

      // SW x2,8(x0) with memory ready in the third access cycle
      run(32'h00202423, 0, 2, 1'b0, 6, -1);
      check("sw_fetch",  obs[0], 32'h1800);
      check("sw_decode", obs[1], 32'h0400);
      check("sw_exec",   obs[2], 32'h0600);
      check("sw_mem0",   obs[3], 32'h0620);
      check("sw_mem1",   obs[4], 32'h0620);
      check("sw_mem2",   obs[5], 32'h0624);
      exp_ret = 2;
      check_retired("sw_retired");

      // BEQ / BNE with alu_zero = 1
      run(32'h00000063, 0, 0, 1'b1, 3, -1);
      check("beq_exec", obs[2], 32'h0086);
      exp_ret = 3;
      check_retired("beq_retired");
      run(32'h00001063, 0, 0, 1'b1, 3, -1);
      check("bne_exec", obs[2], 32'h0084);
      exp_ret = 4;
      check_retired("bne_retired");

      // Illegal opcode traps and holds
      run(32'h0000007F, 0, 0, 1'b0, 22, -1);
      c = 0;
      for (int k = 2; k < 22; k++) if (obs[k] == 13'h0001) c++;
      check("trap_hold_cycles", c, 20);
      check("trap_retired", ret_obs[21], 4);
      do_reset();
      run(32'h0, 5, 0, 1'b0, 1, -1);
      check("post_trap_reset", obs[0], 32'h1000);
      check("post_trap_retired", ret_obs[0], 0);

      // Fetch timeout
      do_reset();
      run(32'h00500093, 1000, 0, 1'b0, 20, -1);
      check("fto_req_cycles", count_bit(B_IREQ, 0, 14), 15);
      check("fto_not_yet", obs[15][B_FAULT], 0);
      check("fto_trap", obs[16], 32'h0001);
      check("fto_no_irwe", count_bit(B_IRWE, 0, 19), 0);

      // Load timeout
      do_reset();
      run(32'h00002083, 0, 1000, 1'b0, 24, -1);
      check("mto_re_cycles", count_bit(B_DRE, 3, 17), 15);
      check("mto_not_yet", obs[18][B_FAULT], 0);
      check("mto_trap", obs[19], 32'h0001);
      check("mto_no_regwe", count_bit(B_REGWE, 0, 23), 0);

      // Reset during a pending load
      do_reset();
      run(32'h00002083, 0, 1000, 1'b0, 6, 4);
      check("mrst_re_before", obs[3][B_DRE], 1);
      check("mrst_re_in_rst", obs[4][B_DRE], 0);
      check("mrst_after", obs[5], 32'h1000);
      check("mrst_retired", ret_obs[5], 0);

      // Random instruction stream
      do_reset();
      for (int i = 0; i < 40; i++) begin
         int          cls, di, dm, fcyc, ncyc, e_re, e_we, e_reg, e_asrc, e_imm;
         bit          z, taken;
         logic [31:0] ins;
         logic [6:0]  opc;
         logic [1:0]  e_op;
         cls = $urandom_range(0, 6);
         di  = $urandom_range(0, 3);
         dm  = $urandom_range(0, 3);
         z   = 1'($urandom_range(0, 1));
         ins = $urandom;
         fcyc = di + 1;
         e_re = 0; e_we = 0; e_reg = 0; e_asrc = 0; e_op = 2'b00; taken = 1'b0;
         case (cls)
            0: begin ins[6:0] = OP_IMM;  ncyc = fcyc + 3; e_reg = 1; e_asrc = 1; e_op = 2'b10; end
            1: begin ins[6:0] = OP_REG;  ncyc = fcyc + 3; e_reg = 1; e_op = 2'b10; end
            2: begin ins[6:0] = OP_LOAD; ncyc = fcyc + dm + 4; e_reg = 1; e_re = dm + 1; e_asrc = dm + 2; end
            3: begin ins[6:0] = OP_STORE; ncyc = fcyc + dm + 3; e_we = dm + 1; e_asrc = dm + 2; end
            4, 5: begin
               ins[6:0] = OP_BR; ins[14:12] = (cls == 5) ? 3'b001 : 3'b000;
               ncyc = fcyc + 2; e_op = 2'b01;
               taken = (cls == 5) ? !z : z;
            end
            default: begin
               if ($urandom_range(0, 1) == 1) begin
                  ins[6:0] = OP_BR; ins[14:12] = 3'($urandom_range(2, 7));
               end else begin
                  opc = 7'($urandom);
                  while (supported(opc)) opc = 7'($urandom);
                  ins[6:0] = opc;
               end
               ncyc = fcyc + 4;
            end
         endcase
         e_imm = (cls == 3) ? ncyc - fcyc : 0;
         run(ins, di, dm, z, ncyc, -1);
         check($sformatf("r%0d_irwe", i), count_bit(B_IRWE, 0, ncyc - 1), 1);
         if (cls == 6) begin
            check($sformatf("r%0d_pcwe", i), count_bit(B_PCWE, 0, ncyc - 1), 0);
            check($sformatf("r%0d_trap", i), obs[ncyc - 1], 32'h0001);
            do_reset();
         end else begin
            check($sformatf("r%0d_pcwe", i), count_bit(B_PCWE, 0, ncyc - 1), 1);
            check($sformatf("r%0d_pcwe_last", i), obs[ncyc - 1][B_PCWE], 1);
            check($sformatf("r%0d_pcsrc", i), count_bit(B_PCSRC, 0, ncyc - 1), taken);
            check($sformatf("r%0d_regwe", i), count_bit(B_REGWE, 0, ncyc - 1), e_reg);
            check($sformatf("r%0d_dre", i), count_bit(B_DRE, 0, ncyc - 1), e_re);
            check($sformatf("r%0d_dwe", i), count_bit(B_DWE, 0, ncyc - 1), e_we);
            check($sformatf("r%0d_wbsel", i), count_bit(B_WBSEL, 0, ncyc - 1), (cls == 2) ? 1 : 0);
            check($sformatf("r%0d_asrc", i), count_bit(B_ASRC, 0, ncyc - 1), e_asrc);
            check($sformatf("r%0d_imm", i), count_bit(B_IMM, 0, ncyc - 1), e_imm);
            check($sformatf("r%0d_aluop", i), obs[fcyc + 1][8:7], e_op);
            exp_ret++;
            check_retired($sformatf("r%0d_retired", i));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
